// File: rtl/mesh_generator_if.sv
// mesh_generator_if: terminal-side bundle of the mesh traffic generator.
// slave = generator side, master = terminal agents side.
interface mesh_generator_if #(
   parameter int ROWS    = 4,
   parameter int COLUMS  = 4,
   parameter int pckg_sz = 40
);
   localparam int N = 2*ROWS + 2*COLUMS;

   logic [N-1:0][pckg_sz-1:0] data_out_i_in;
   logic [N-1:0]              pndng_i_in;
   logic [N-1:0]              popin;
   logic [N-1:0][pckg_sz-1:0] data_out;
   logic [N-1:0]              pndng;
   logic [N-1:0]              pop;

   modport master (output data_out_i_in, pndng_i_in, pop,
                   input  popin, data_out, pndng);
   modport slave  (input  data_out_i_in, pndng_i_in, pop,
                   output popin, data_out, pndng);
endinterface

// File: rtl/mesh_generator.sv
// mesh_generator: border-terminal traffic model for a ROWS x COLUMS mesh.
// Every terminal has an input and an output FIFO; a round-robin arbiter moves
// one packet per cycle from an input FIFO to its destination output FIFO(s),
// unicast by (row, column) address or broadcast when the payload equals bdcst.
// Build option: define SELF_LOOPBACK_EN to deliver packets addressed to their
// own source terminal instead of dropping them.
module mesh_generator #(
   parameter int                  ROWS       = 4,
   parameter int                  COLUMS     = 4,
   parameter int                  pckg_sz    = 40,
   parameter int                  fifo_depth = 4,
   parameter logic [pckg_sz-18:0] bdcst      = {(pckg_sz-18){1'b1}}
) (
   input logic             clk,
   input logic             reset,
   mesh_generator_if.slave bus
);
   localparam int N  = 2*ROWS + 2*COLUMS;
   localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
   localparam int CW = $clog2(fifo_depth + 1);
   localparam int AW = (N > 1) ? $clog2(N) : 1;
   localparam int PL = pckg_sz - 17;

   // {row, column} address of border terminal t
   function automatic logic [7:0] f_addr(input int unsigned t);
      int unsigned r, c;
      if (t < COLUMS) begin
         r = 0;                        c = t + 1;
      end else if (t < COLUMS + ROWS) begin
         r = t - COLUMS + 1;           c = 0;
      end else if (t < 2*COLUMS + ROWS) begin
         r = ROWS + 1;                 c = t - COLUMS - ROWS + 1;
      end else begin
         r = t - 2*COLUMS - ROWS + 1;  c = COLUMS + 1;
      end
      return {4'(r), 4'(c)};
   endfunction

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (32'(p) == fifo_depth - 1) ? '0 : p + 1'b1;
   endfunction

   logic [pckg_sz-1:0]        r_in_mem  [N][fifo_depth];
   logic [PW-1:0]             r_in_rd   [N];
   logic [PW-1:0]             r_in_wr   [N];
   logic [CW-1:0]             r_in_cnt  [N];
   logic [pckg_sz-1:0]        r_out_mem [N][fifo_depth];
   logic [PW-1:0]             r_out_rd  [N];
   logic [PW-1:0]             r_out_wr  [N];
   logic [CW-1:0]             r_out_cnt [N];
   logic [AW-1:0]             r_ptr;

   logic [N-1:0]              w_push_in, w_pop_in, w_in_ne;
   logic [N-1:0]              w_push_out, w_pop_out, w_out_ne, w_out_space;
   logic [N-1:0]              w_dmask [N];
   logic                      w_grant;
   logic [AW-1:0]             w_gidx, w_cand;
   logic [pckg_sz-1:0]        w_gdata;
   logic [N-1:0][pckg_sz-1:0] w_data_out;

   // FIFO status flags and the agent-side handshakes
   always_comb begin
      w_push_in   = '0;
      w_in_ne     = '0;
      w_pop_out   = '0;
      w_out_ne    = '0;
      w_out_space = '0;
      w_data_out  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         w_in_ne[i]     = (r_in_cnt[i] != '0);
         w_push_in[i]   = bus.pndng_i_in[i] && (r_in_cnt[i] != CW'(fifo_depth)) && !reset;
         w_out_ne[i]    = (r_out_cnt[i] != '0);
         w_pop_out[i]   = bus.pop[i] && w_out_ne[i];
         // a same-cycle pop frees the slot the incoming packet will use
         w_out_space[i] = (r_out_cnt[i] != CW'(fifo_depth)) || w_pop_out[i];
         w_data_out[i]  = w_out_ne[i] ? r_out_mem[i][r_out_rd[i]] : '0;
      end
   end

   assign bus.popin    = w_push_in;
   assign bus.data_out = w_data_out;
   assign bus.pndng    = w_out_ne;

   // destination set of the head packet of every input FIFO (empty set = drop)
   always_comb begin
      for (int unsigned s = 0; s < N; s++) begin
         w_dmask[s] = '0;
         if (r_in_mem[s][r_in_rd[s]][PL-1:0] == bdcst) begin
            w_dmask[s]    = '1;
            w_dmask[s][s] = 1'b0;
         end else begin
            for (int unsigned d = 0; d < N; d++) begin
`ifdef SELF_LOOPBACK_EN
               if (f_addr(d) == r_in_mem[s][r_in_rd[s]][pckg_sz-9 -: 8])
`else
               if ((d != s) && (f_addr(d) == r_in_mem[s][r_in_rd[s]][pckg_sz-9 -: 8]))
`endif
                  w_dmask[s][d] = 1'b1;
            end
         end
      end
   end

   // round-robin pick of the first movable head starting at r_ptr
   always_comb begin
      w_grant = 1'b0;
      w_gidx  = '0;
      w_cand  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_cand = AW'((32'(r_ptr) + k) % N);
         if (!w_grant && w_in_ne[w_cand] && ((w_dmask[w_cand] & ~w_out_space) == '0)) begin
            w_grant = 1'b1;
            w_gidx  = w_cand;
         end
      end
      w_pop_in = '0;
      if (w_grant) w_pop_in[w_gidx] = 1'b1;
      w_push_out = w_grant ? w_dmask[w_gidx] : '0;
      w_gdata    = r_in_mem[w_gidx][r_in_rd[w_gidx]];
   end

   // FIFO storage; contents are only observed while the FIFO is non-empty
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < N; i++) begin
         if (w_push_in[i])  r_in_mem[i][r_in_wr[i]]   <= bus.data_out_i_in[i];
         if (w_push_out[i]) r_out_mem[i][r_out_wr[i]] <= w_gdata;
      end
   end

   // FIFO pointers, occupancy counters and the arbiter pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < N; i++) begin
            r_in_rd[i]   <= '0;
            r_in_wr[i]   <= '0;
            r_in_cnt[i]  <= '0;
            r_out_rd[i]  <= '0;
            r_out_wr[i]  <= '0;
            r_out_cnt[i] <= '0;
         end
         r_ptr <= '0;
      end else begin
         for (int unsigned i = 0; i < N; i++) begin
            if (w_push_in[i])  r_in_wr[i]  <= f_inc(r_in_wr[i]);
            if (w_pop_in[i])   r_in_rd[i]  <= f_inc(r_in_rd[i]);
            r_in_cnt[i]  <= r_in_cnt[i] + CW'(w_push_in[i]) - CW'(w_pop_in[i]);
            if (w_push_out[i]) r_out_wr[i] <= f_inc(r_out_wr[i]);
            if (w_pop_out[i])  r_out_rd[i] <= f_inc(r_out_rd[i]);
            r_out_cnt[i] <= r_out_cnt[i] + CW'(w_push_out[i]) - CW'(w_pop_out[i]);
         end
         if (w_grant) r_ptr <= (32'(w_gidx) == N - 1) ? '0 : w_gidx + 1'b1;
      end
   end
endmodule

// File: tb/tb_mesh_generator.sv
// tb_mesh_generator: directed bench for mesh_generator at default parameters
// (4x4 mesh, 16 terminals, 40-bit packets, depth-4 FIFOs).
module tb_mesh_generator;
  localparam int ROWS = 4, COLUMS = 4, PSZ = 40, N = 16;
  localparam logic [22:0] BCAST = 23'h3FFFFF;
  // terminal address table, written out by hand
  localparam logic [3:0] TR [N] = '{0,0,0,0, 1,2,3,4, 5,5,5,5, 1,2,3,4};
  localparam logic [3:0] TC [N] = '{1,2,3,4, 0,0,0,0, 1,2,3,4, 5,5,5,5};
`ifdef SELF_LOOPBACK_EN
  localparam logic [15:0] SELF_EXP = 16'h0004;
`else
  localparam logic [15:0] SELF_EXP = 16'h0000;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0, failures = 0;
  int   sent, rcv, prev, src, nexp;
  logic acc;
  logic [N-1:0]     got;
  logic [PSZ-1:0]   pkt_a, pkt_b;

  mesh_generator_if #(.ROWS(ROWS), .COLUMS(COLUMS), .pckg_sz(PSZ)) bus();

  mesh_generator #(.ROWS(ROWS), .COLUMS(COLUMS), .pckg_sz(PSZ), .fifo_depth(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5ns clk = ~clk;

  function automatic logic [PSZ-1:0] mk(input logic [3:0] r, input logic [3:0] c,
                                        input logic [22:0] pl);
    return {8'h00, r, c, 1'b0, pl};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.pndng_i_in    = '1;
    bus.data_out_i_in = '0;
    bus.pop           = '0;
    #1ns;
    chk("rst_pndng_early", bus.pndng, 16'h0000);
    chk("rst_popin_early", bus.popin, 16'h0000);
    #47ns;
    chk("rst_pndng_late", bus.pndng, 16'h0000);
    chk("rst_popin_late", bus.popin, 16'h0000);
    chk("rst_data_out0", bus.data_out[0], 40'h0);
    #2ns;
    reset = 1'b0;
    bus.pndng_i_in = '0;

    pkt_a = mk(4'd5, 4'd2, 23'h15);
    bus.data_out_i_in[0] = pkt_a;
    bus.pndng_i_in[0]    = 1'b1;
    #1ns;
    chk("first_offer_popin", bus.popin, 16'h0001);
    tick();
    bus.pndng_i_in[0] = 1'b0;
    chk("uni_not_yet", bus.pndng, 16'h0000);
    tick();
    chk("uni_pndng", bus.pndng, 16'h0200);
    chk("uni_data", bus.data_out[9], pkt_a);
    bus.pop[9] = 1'b1;
    tick();
    bus.pop[9] = 1'b0;
    chk("uni_popped", bus.pndng, 16'h0000);

    bus.pop = '1;
    tick();
    bus.pop = '0;
    tick();
    chk("empty_pop_pndng", bus.pndng, 16'h0000);

    sent = 0;
    for (int unsigned cyc = 0; cyc < 20; cyc++) begin
      bus.data_out_i_in[3] = mk(4'd5, 4'd3, 23'(100 + sent));
      bus.pndng_i_in[3]    = 1'b1;
      #1ns;
      acc = bus.popin[3];
      @(posedge clk);
      if (acc) sent++;
      @(negedge clk);
    end
    bus.data_out_i_in[3] = mk(4'd5, 4'd3, 23'(100 + sent));
    #1ns;
    chk("burst_accepted", sent, 8);
    chk("burst_popin_low", bus.popin[3], 1'b0);
    chk("burst_out_pndng", bus.pndng, 16'h0400);
    chk("burst_head", bus.data_out[10], mk(4'd5, 4'd3, 23'd100));
    rcv = 0;
    for (int unsigned cyc = 0; cyc < 40 && rcv < 10; cyc++) begin
      if (sent < 10) begin
        bus.data_out_i_in[3] = mk(4'd5, 4'd3, 23'(100 + sent));
        bus.pndng_i_in[3]    = 1'b1;
      end else begin
        bus.pndng_i_in[3] = 1'b0;
      end
      bus.pop[10] = bus.pndng[10];
      if (bus.pndng[10]) begin
        chk("burst_order", bus.data_out[10], mk(4'd5, 4'd3, 23'(100 + rcv)));
        rcv++;
      end
      #1ns;
      acc = bus.popin[3];
      @(posedge clk);
      if (acc) sent++;
      @(negedge clk);
    end
    bus.pop[10]       = 1'b0;
    bus.pndng_i_in[3] = 1'b0;
    chk("burst_all_rcvd", rcv, 10);
    chk("burst_all_sent", sent, 10);
    chk("burst_drained", bus.pndng, 16'h0000);

    for (int unsigned i = 0; i < N; i++)
      bus.data_out_i_in[i] = mk(TR[(i + 1) % N], TC[(i + 1) % N], 23'(16'h1000 + i));
    bus.pndng_i_in = '1;
    #1ns;
    chk("all_popin", bus.popin, 16'hFFFF);
    tick();
    bus.pndng_i_in = '0;
    got  = '0;
    prev = -1;
    nexp = 4;
    for (int unsigned cyc = 0; cyc < 24; cyc++) begin
      for (int unsigned d = 0; d < N; d++) begin
        if (bus.pndng[d]) begin
          src = (d + N - 1) % N;
          chk("all_data", bus.data_out[d], mk(TR[d], TC[d], 23'(16'h1000 + src)));
          chk("all_once", got[d], 1'b0);
          chk("all_rr_order", src, nexp);
          got[d] = 1'b1;
          prev   = src;
          nexp   = (src + 1) % N;
        end
      end
      bus.pop = bus.pndng;
      tick();
    end
    bus.pop = '0;
    chk("all_delivered", got, 16'hFFFF);
    chk("all_last_src", prev, 3);

    pkt_a = mk(4'd0, 4'd0, BCAST);
    bus.data_out_i_in[5] = pkt_a;
    bus.pndng_i_in[5]    = 1'b1;
    tick();
    bus.pndng_i_in[5] = 1'b0;
    tick();
    chk("bcast_pndng", bus.pndng, 16'hFFDF);
    for (int unsigned d = 0; d < N; d++)
      if (d != 5) chk("bcast_data", bus.data_out[d], pkt_a);
    bus.pop = '1;
    tick();
    bus.pop = '0;
    chk("bcast_popped", bus.pndng, 16'h0000);

    pkt_a = mk(4'd0, 4'd3, 23'h22);
    pkt_b = mk(4'd0, 4'd1, 23'h23);
    bus.data_out_i_in[2] = pkt_a;
    bus.pndng_i_in[2]    = 1'b1;
    tick();
    bus.data_out_i_in[2] = pkt_b;
    tick();
    bus.pndng_i_in[2] = 1'b0;
    chk("self_pndng", bus.pndng, SELF_EXP);
    tick();
    chk("self_next_pndng", bus.pndng, SELF_EXP | 16'h0001);
    chk("self_next_data", bus.data_out[0], pkt_b);
`ifdef SELF_LOOPBACK_EN
    chk("self_loop_data", bus.data_out[2], pkt_a);
`endif
    bus.pop = '1;
    tick();
    bus.pop = '0;
    chk("self_popped", bus.pndng, 16'h0000);

    pkt_a = mk(4'd5, 4'd2, 23'h31);
    bus.data_out_i_in[0] = pkt_a;
    bus.pndng_i_in[0]    = 1'b1;
    @(posedge clk);
    #2ns;
    reset = 1'b1;
    #1ns;
    chk("midrst_pndng", bus.pndng, 16'h0000);
    chk("midrst_popin", bus.popin, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    bus.pndng_i_in = '0;
    tick();
    tick();
    chk("midrst_discard", bus.pndng, 16'h0000);
    bus.pndng_i_in[0] = 1'b1;
    tick();
    bus.pndng_i_in[0] = 1'b0;
    tick();
    chk("midrst_resume", bus.pndng, 16'h0200);
    chk("midrst_resume_data", bus.data_out[9], pkt_a);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
